// File: rtl/flag_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : flag_entry_ctrl
// Brief    : Debounced button-to-byte sequencer feeding the flag capture path.
// Revision : 1.0
// ============================================================================
module flag_entry_ctrl #(
    parameter int NBYTES    = 38,
    parameter int DB_CYCLES = 2,
    parameter int TIMEOUT   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic [7:0] sw,
    input  logic       clr,
    input  logic       cap_ready,
    output logic       cap_valid,
    output logic [7:0] cap_data,
    output logic [5:0] byte_idx,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int c_DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int c_TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_DB_W-1:0] c_DB_LAST  = c_DB_W'(DB_CYCLES - 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST  = c_TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [5:0]        c_IDX_LAST = 6'(NBYTES - 1);
    localparam logic              c_TO_EN    = (TIMEOUT > 0);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_PRESS = 3'd1,
        S_ISSUE      = 3'd2,
        S_WAIT_REL   = 3'd3,
        S_DONE       = 3'd4,
        S_ERR        = 3'd5
    } state_t;

    state_t              r_state;
    logic                r_sync1;
    logic                r_sync2;
    logic [c_DB_W-1:0]   r_db_cnt;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic                r_cap_valid;
    logic [7:0]          r_cap_data;
    logic [5:0]          r_idx;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic                w_want;
    logic                w_match;
    logic                w_db_hit;
    logic                w_waiting;
    logic                w_to_hit;

    // Only WAIT_REL waits for a low level; every other debouncing state wants a press.
    assign w_want    = (r_state != S_WAIT_REL);
    assign w_match   = (r_sync2 == w_want);
    assign w_db_hit  = w_match && (r_db_cnt == c_DB_LAST);
    assign w_waiting = (r_state == S_WAIT_PRESS) || (r_state == S_WAIT_REL);
    assign w_to_hit  = c_TO_EN && w_waiting && (r_to_cnt == c_TO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_db_cnt    <= '0;
            r_to_cnt    <= '0;
            r_cap_valid <= 1'b0;
            r_cap_data  <= 8'h00;
            r_idx       <= 6'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
            if (clr) begin
                r_state     <= S_IDLE;
                r_db_cnt    <= '0;
                r_to_cnt    <= '0;
                r_cap_valid <= 1'b0;
                r_idx       <= 6'd0;
                r_busy      <= 1'b0;
                r_done      <= 1'b0;
                r_err       <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_WAIT_PRESS: begin
                        // A debounced press beats a timeout expiring on the same edge.
                        if (w_db_hit) begin
                            r_state     <= S_ISSUE;
                            r_cap_data  <= sw;
                            r_cap_valid <= 1'b1;
                            r_busy      <= 1'b1;
                            r_db_cnt    <= '0;
                            r_to_cnt    <= '0;
                        end else if (w_to_hit) begin
                            r_state  <= S_ERR;
                            r_err    <= 1'b1;
                            r_busy   <= 1'b0;
                            r_db_cnt <= '0;
                        end else begin
                            r_db_cnt <= w_match ? r_db_cnt + 1'b1 : '0;
                            if (r_state == S_WAIT_PRESS) begin
                                r_to_cnt <= r_to_cnt + 1'b1;
                            end
                        end
                    end
                    S_ISSUE: begin
                        if (cap_ready) begin
                            r_cap_valid <= 1'b0;
                            r_idx       <= r_idx + 6'd1;
                            r_db_cnt    <= '0;
                            if (r_idx == c_IDX_LAST) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= S_WAIT_REL;
                            end
                        end
                    end
                    S_WAIT_REL: begin
                        if (w_to_hit) begin
                            r_state  <= S_ERR;
                            r_err    <= 1'b1;
                            r_busy   <= 1'b0;
                            r_db_cnt <= '0;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                            if (w_db_hit) begin
                                r_state  <= S_WAIT_PRESS;
                                r_db_cnt <= '0;
                            end else begin
                                r_db_cnt <= w_match ? r_db_cnt + 1'b1 : '0;
                            end
                        end
                    end
                    S_DONE, S_ERR: begin
                        // Terminal until clr or reset; the button is ignored.
                        r_db_cnt <= '0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign cap_valid = r_cap_valid;
    assign cap_data  = r_cap_data;
    assign byte_idx  = r_idx;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_flag_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_flag_entry_ctrl
// Brief    : Scoreboard bench for flag_entry_ctrl (main DUT plus short-timeout DUT).
// Revision : 1.0
// ============================================================================
module tb_flag_entry_ctrl;

    localparam int NB = 38;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_raw;
    logic [7:0] sw;
    logic       clr;
    logic       cap_ready;
    logic       rnd_ready;

    logic       cap_valid, busy, done, err;
    logic [7:0] cap_data;
    logic [5:0] byte_idx;
    logic       to_valid, to_busy, to_done, to_err;
    logic [7:0] to_data;
    logic [5:0] to_idx;

    always #5 clk = ~clk;

    flag_entry_ctrl #(.NBYTES(NB), .DB_CYCLES(2), .TIMEOUT(1000)) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .sw(sw), .clr(clr),
        .cap_ready(cap_ready), .cap_valid(cap_valid), .cap_data(cap_data),
        .byte_idx(byte_idx), .busy(busy), .done(done), .err(err)
    );

    flag_entry_ctrl #(.NBYTES(NB), .DB_CYCLES(2), .TIMEOUT(20)) dut_to (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .sw(sw), .clr(clr),
        .cap_ready(cap_ready), .cap_valid(to_valid), .cap_data(to_data),
        .byte_idx(to_idx), .busy(to_busy), .done(to_done), .err(to_err)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_xfer = 0;
    int         m_idx = 0;
    logic [7:0] q_data[$];
    int         q_idx[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every offered cycle must carry the queued byte.
    always @(negedge clk) begin
        if (rst && !clr && cap_valid) begin
            if (q_data.size() > 0) chk("cap_data", 32'(cap_data), 32'(q_data[0]));
            if (cap_ready) begin
                n_xfer++;
                if (q_data.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_xfer: got data %02h idx %0d, required no transfer", cap_data, byte_idx);
                end else begin
                    chk("xfer_idx", 32'(byte_idx), 32'(q_idx[0]));
                    void'(q_data.pop_front());
                    void'(q_idx.pop_front());
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_ready) cap_ready = 1'($urandom_range(0, 1));
    end

    task automatic expect_byte(input logic [7:0] d);
        q_data.push_back(d);
        q_idx.push_back(m_idx);
        m_idx++;
    endtask

    task automatic clr_all();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        m_idx = 0;
        q_data.delete();
        q_idx.delete();
        chk("clr_idx", 32'(byte_idx), 0);
        chk("clr_done", 32'(done), 0);
        chk("clr_err", 32'(err), 0);
    endtask

    task automatic wait_capture(input int base);
        int k = 0;
        while (!cap_valid && n_xfer == base && k < 400) begin tick(1); k++; end
        n_cmp++;
        if (!cap_valid && n_xfer == base) begin
            n_bad++;
            $display("FAIL capture_wait: got no offer after %0d cycles, required an offer", k);
        end
    endtask

    task automatic wait_xfer(input int target);
        int k = 0;
        while (n_xfer < target && k < 400) begin tick(1); k++; end
        chk("xfer_wait", 32'(n_xfer), 32'(target));
    endtask

    // One button press carrying byte d; sw is scrambled once the byte is captured.
    task automatic send(input logic [7:0] d, input int hold, input int gap);
        int base;
        base = n_xfer;
        expect_byte(d);
        sw = d;
        btn_raw = 1'b1;
        tick(hold);
        btn_raw = 1'b0;
        wait_capture(base);
        sw = 8'($urandom);
        wait_xfer(base + 1);
        tick(gap);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got no completion, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int n;
        rst = 1'b0; btn_raw = 1'b0; sw = 8'h00; clr = 1'b0; cap_ready = 1'b0; rnd_ready = 1'b0;
        tick(3);
        chk("rst_valid", 32'(cap_valid), 0);
        chk("rst_data", 32'(cap_data), 0);
        chk("rst_idx", 32'(byte_idx), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b1;
        tick(2);

        // Press-to-offer latency and single-cycle offer with ready high.
        cap_ready = 1'b1;
        expect_byte(8'h66);
        sw = 8'h66;
        btn_raw = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            if (k == 2) btn_raw = 1'b0;
            chk("t1_valid", 32'(cap_valid), 32'(k == 4));
        end
        chk("t1_idx", 32'(byte_idx), 1);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_xfers", 32'(n_xfer), 1);

        // Held button yields one byte only.
        clr_all();
        b = n_xfer;
        send(8'h66, 55, 4);
        chk("t2_one_xfer", 32'(n_xfer - b), 1);
        chk("t2_valid_low", 32'(cap_valid), 0);
        send(8'h6C, 2, 4);
        chk("t2_idx", 32'(byte_idx), 2);
        chk("t2_two_xfer", 32'(n_xfer - b), 2);

        // Full 38-byte stream at fixed cadence.
        clr_all();
        b = n_xfer;
        for (int i = 0; i < NB; i++) begin
            expect_byte(8'($urandom));
            sw = q_data[q_data.size() - 1];
            btn_raw = 1'b1;
            tick(2);
            btn_raw = 1'b0;
            tick(4);
        end
        tick(6);
        chk("t3_xfers", 32'(n_xfer - b), NB);
        chk("t3_done", 32'(done), 1);
        chk("t3_idx", 32'(byte_idx), NB);
        chk("t3_busy", 32'(busy), 0);
        for (int i = 0; i < 2; i++) begin
            sw = 8'($urandom);
            btn_raw = 1'b1;
            tick(3);
            btn_raw = 1'b0;
            tick(5);
        end
        chk("t3_ignored", 32'(n_xfer - b), NB);
        chk("t3_idx_hold", 32'(byte_idx), NB);
        chk("t3_done_hold", 32'(done), 1);

        // Back-pressure: offer held, data stable while sw moves.
        clr_all();
        b = n_xfer;
        cap_ready = 1'b0;
        expect_byte(8'hA5);
        sw = 8'hA5;
        btn_raw = 1'b1;
        tick(2);
        btn_raw = 1'b0;
        wait_capture(b);
        for (int k = 0; k < 10; k++) begin
            sw = 8'($urandom);
            chk("t4_valid_hold", 32'(cap_valid), 1);
            tick(1);
        end
        chk("t4_no_xfer", 32'(n_xfer - b), 0);
        cap_ready = 1'b1;
        tick(1);
        chk("t4_valid_drop", 32'(cap_valid), 0);
        chk("t4_idx", 32'(byte_idx), 1);
        chk("t4_xfer", 32'(n_xfer - b), 1);
        tick(4);

        // Inter-byte timeout on the 20-cycle instance.
        clr_all();
        expect_byte(8'h33);
        sw = 8'h33;
        btn_raw = 1'b1;
        tick(2);
        btn_raw = 1'b0;
        tick(3);
        chk("t5_to_xfer_valid", 32'(to_valid), 0);
        chk("t5_to_idx", 32'(to_idx), 1);
        tick(19);
        chk("t5_err_early", 32'(to_err), 0);
        tick(1);
        chk("t5_err", 32'(to_err), 1);
        chk("t5_err_idx", 32'(to_idx), 1);
        chk("t5_err_busy", 32'(to_busy), 0);
        clr_all();
        chk("t5_clr_err", 32'(to_err), 0);
        chk("t5_clr_idx", 32'(to_idx), 0);
        chk("t5_clr_busy", 32'(to_busy), 0);

        // Press debounced on the very edge the timeout expires: press wins.
        expect_byte(8'h5A);
        sw = 8'h5A;
        btn_raw = 1'b1;
        tick(2);
        btn_raw = 1'b0;
        tick(19);
        expect_byte(8'hC3);
        sw = 8'hC3;
        btn_raw = 1'b1;
        tick(2);
        btn_raw = 1'b0;
        tick(2);
        chk("t5b_valid", 32'(to_valid), 1);
        chk("t5b_err", 32'(to_err), 0);
        chk("t5b_data", 32'(to_data), 32'h C3);
        tick(1);
        chk("t5b_idx", 32'(to_idx), 2);
        tick(6);

        // Asynchronous reset while an offer is pending.
        clr_all();
        cap_ready = 1'b0;
        sw = 8'h9E;
        btn_raw = 1'b1;
        tick(2);
        btn_raw = 1'b0;
        wait_capture(n_xfer);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_valid", 32'(cap_valid), 0);
        chk("t6_data", 32'(cap_data), 0);
        chk("t6_idx", 32'(byte_idx), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_done", 32'(done), 0);
        chk("t6_err", 32'(err), 0);
        tick(1);
        rst = 1'b1;
        m_idx = 0;
        tick(3);
        cap_ready = 1'b1;
        send(8'hE7, 2, 4);
        chk("t6_restart_idx", 32'(byte_idx), 1);

        // Randomized streams with random ready and press timing.
        for (int r = 0; r < 2; r++) begin
            cap_ready = 1'b1;
            clr_all();
            rnd_ready = 1'b1;
            n = (r == 0) ? NB : int'($urandom_range(3, 20));
            for (int i = 0; i < n; i++) begin
                send(8'($urandom), int'($urandom_range(2, 6)), int'($urandom_range(4, 8)));
            end
            rnd_ready = 1'b0;
            cap_ready = 1'b1;
            tick(4);
            chk("rnd_idx", 32'(byte_idx), 32'(m_idx));
            chk("rnd_done", 32'(done), 32'(m_idx == NB));
            chk("rnd_err", 32'(err), 0);
        end

        tick(5);
        chk("queue_empty", 32'(q_data.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/flag_entry_ctrl.md
Name: flag_entry_ctrl

Overview:
- Front-end sequencer for the flag vending machine's byte-capture datapath.
- Turns the raw left button and the 8 switches into a clean stream of byte transfers. It synchronises and debounces the button, then issues exactly one valid/ready transfer per press.
- Counts bytes up to a full flag and flags completion, inter-byte timeout, or abort.
- Sits between the board I/O and the capture datapath. The datapath's ready gates each transfer.

Parameters:
- NBYTES, 38: bytes per flag entry; byte_idx counts 0..NBYTES-1.
- DB_CYCLES, 2: consecutive synchronised-level cycles needed to accept a press or release (min 1).
- TIMEOUT, 1000: max idle cycles between an accepted byte and the next press; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low (rst=0 resets).
- btn_raw  in  1  raw, asynchronous BTNL level.
- sw  in  8  switch byte.
- clr  in  1  synchronous clear/abort pulse, active-high.
- cap_ready  in  1  datapath accepts cap_data this cycle.
- cap_valid  out  1  byte offered to datapath.
- cap_data  out  8  byte offered; stable while cap_valid=1.
- byte_idx  out  6  index of the next byte to be transferred.
- busy  out  1  entry in progress (byte_idx>0, or a press is being serviced).
- done  out  1  NBYTES bytes transferred; sticky.
- err  out  1  inter-byte timeout; sticky.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; sync FFs, debounce and timeout counters cleared.
  - cap_valid=0, cap_data=0, byte_idx=0, busy=0, done=0, err=0.
- Sync: 2-FF synchroniser on btn_raw gives btn_s, which is 2 cycles late.
- Debounce: counter tracks consecutive cycles of btn_s equal to the level the state waits for. It resets on any mismatch and on every state change. Reaching DB_CYCLES counts as the event.
- States:
  - IDLE / WAIT_PRESS: wait for btn_s=1 for DB_CYCLES cycles. On that event, register cap_data<=sw and go to ISSUE. From press edge to cap_valid is 2+DB_CYCLES cycles.
  - ISSUE: cap_valid=1, cap_data held. When cap_valid&cap_ready, the transfer happens that cycle:
    - cap_valid drops next cycle and byte_idx increments.
    - If the transferred index was NBYTES-1, go to DONE; otherwise go to WAIT_RELEASE.
    - ISSUE has no timeout; it waits indefinitely for ready.
  - WAIT_RELEASE: wait for btn_s=0 for DB_CYCLES cycles, then go to WAIT_PRESS. A held button never produces a second byte.
  - DONE: done=1, busy=0, byte_idx=NBYTES. Button ignored. Leaves only on clr or reset.
  - ERR: err=1, busy=0, byte_idx frozen at its value on entry. Button ignored. Leaves only on clr or reset.
- Timeout (TIMEOUT>0):
  - Counter runs in WAIT_RELEASE and WAIT_PRESS whenever byte_idx>0. It clears on entry to ISSUE.
  - When it reaches TIMEOUT, go to ERR.
  - Never runs in IDLE, i.e. before the first byte.
- clr: in any state, next cycle gives state=IDLE, byte_idx=0, done=0, err=0, cap_valid=0. It aborts an in-flight offer with no transfer. clr has priority over a simultaneous cap_ready.
- Simultaneous timeout expiry and debounced press in the same cycle: press wins, go to ISSUE.
- byte_idx width must hold NBYTES (6 bits for 38). No wrap: DONE is terminal.
- busy = (state==ISSUE) | (byte_idx>0 & state in {WAIT_PRESS, WAIT_RELEASE}).

Test Plan:
1. Reset, then sw=8'h66, btn high 2 cycles, cap_ready=1 -> cap_valid high for exactly 1 cycle, 4 cycles after the press edge; cap_data=8'h66; byte_idx 0->1; busy=1.
2. Hold btn high for 50 cycles after one transfer -> no second cap_valid. Release and press again with sw=8'h6C -> second transfer of 8'h6C, byte_idx=2.
3. Bench-style stream of 38 bytes, each pressed 2 cycles and released 4 cycles -> 38 transfers in order, data matching; done=1 after the 38th; byte_idx=38; further presses ignored.
4. cap_ready held 0 for 10 cycles during ISSUE, sw changed mid-wait -> cap_valid stays 1; cap_data keeps the originally sampled value; transfer happens on the cycle ready rises.
5. TIMEOUT=20: one byte transferred, then no press -> err=1 exactly 20 cycles after WAIT_RELEASE starts counting; byte_idx=1. clr -> err=0, byte_idx=0, state IDLE.
6. Assert rst=0 while in ISSUE with cap_valid=1 -> all outputs 0 immediately, without waiting for a clock edge. Release reset -> next press starts at byte_idx=0.
